// File: rtl/jtdsp16_sout.sv
// jtdsp16_sout: FIFO-buffered serial output unit driving ock/sdo/old/ose with channel tagging.
module jtdsp16_sout #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int CKDIV = 2,
  parameter int CH    = 2,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int DVW  = (CKDIV > 1) ? $clog2(CKDIV) : 1,
  localparam int BW   = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          msb_first,
  input  logic          ovf_clr,
  input  logic          doen,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          ovf,
  output logic          ock,
  output logic          sdo,
  output logic          old,
  output logic          ose,
  output logic [CW-1:0] chan
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q;
  logic [DVW-1:0] div_q;
  logic ock_q, ovf_q;
  logic [DW-1:0] sh_q, sh_d, shifted, head;
  logic msb_q, msb_d, sdo_q, sdo_d, old_q, old_d, ose_q, ose_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CW-1:0] chan_q, chan_d;
  logic wrap, fe, run, last, pop, push, drop;
  assign wrap  = div_q == DVW'(CKDIV - 1);
  assign fe    = cen && wrap && ock_q;
  assign run   = fe && doen;
  assign last  = state_q == IDLE || bit_q == '0;
  assign pop   = run && last && !empty;
  assign push  = cen && wr && (!full || pop);
  assign drop  = cen && wr && full && !pop;
  assign head  = mem_q[rp_q];
  assign full  = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign ovf   = ovf_q;
  assign ock   = ock_q;
  assign ose   = ose_q;
  assign chan  = chan_q;
  // doen gates the serial pins combinationally so a pause blanks them at once
  assign sdo   = sdo_q & doen;
  assign old   = old_q & doen;
  assign shifted = msb_q ? sh_q << 1 : sh_q >> 1;
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    msb_d   = msb_q;
    bit_d   = bit_q;
    sdo_d   = sdo_q;
    old_d   = old_q;
    ose_d   = ose_q;
    chan_d  = chan_q;
    if (run && state_q == SHIFT && bit_q == '0)
      chan_d = (chan_q == CW'(CH - 1)) ? '0 : chan_q + 1'b1;
    if (pop) begin
      state_d = SHIFT;
      sh_d    = head;
      msb_d   = msb_first;
      sdo_d   = msb_first ? head[DW-1] : head[0];
      old_d   = 1'b1;
      ose_d   = 1'b0;
      bit_d   = BW'(DW - 1);
    end else if (run && state_q == SHIFT) begin
      if (bit_q != '0) begin
        sh_d  = shifted;
        sdo_d = msb_q ? shifted[DW-1] : shifted[0];
        old_d = 1'b0;
        bit_d = bit_q - 1'b1;
      end else begin
        state_d = IDLE;
        sdo_d   = 1'b0;
        old_d   = 1'b0;
        ose_d   = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      div_q   <= '0;
      ock_q   <= 1'b0;
      ovf_q   <= 1'b0;
      sh_q    <= '0;
      msb_q   <= 1'b0;
      bit_q   <= '0;
      sdo_q   <= 1'b0;
      old_q   <= 1'b0;
      ose_q   <= 1'b1;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      msb_q   <= msb_d;
      bit_q   <= bit_d;
      sdo_q   <= sdo_d;
      old_q   <= old_d;
      ose_q   <= ose_d;
      chan_q  <= chan_d;
      if (cen) div_q <= wrap ? '0 : div_q + 1'b1;
      if (cen && wrap) ock_q <= ~ock_q;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      if (push && !pop) level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
      else if (cen && ovf_clr) ovf_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_jtdsp16_sout.sv
// tb_jtdsp16_sout: directed checks of the serial output unit with default parameters and cen held high.
module tb_jtdsp16_sout;
  logic clk = 0, rst = 1, cen = 1, wr = 0, msb_first = 1, ovf_clr = 0, doen = 1;
  logic [15:0] din = '0;
  logic full, empty, ovf, ock, sdo, old, ose;
  logic [2:0] level;
  logic [0:0] chan;
  int checks = 0, errors = 0, cyc = 0, ones = 0;

  jtdsp16_sout dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr), .din(din), .msb_first(msb_first),
    .ovf_clr(ovf_clr), .doen(doen), .full(full), .empty(empty), .level(level),
    .ovf(ovf), .ock(ock), .sdo(sdo), .old(old), .ose(ose), .chan(chan)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic nx();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ock", ock, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_old", old, 0);
    chk("rst_ose", ose, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_chan", chan, 0);
  endtask

  // Entered on the sample right after the loading falling edge; leaves one sample after the word ends.
  task automatic run_word(input logic [15:0] w, input logic m, input logic [0:0] ch);
    logic e;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) nx();
      e = m ? w[15 - i / 4] : w[i / 4];
      chk("word_sdo", sdo, e);
      chk("word_old", old, i < 4);
      chk("word_ose", ose, 0);
      chk("word_chan", chan, ch);
    end
    nx();
  endtask

  initial begin
    repeat (3) nx();
    chk_reset();
    rst = 0;
    cyc = 0;
    wr = 1; din = 16'hA5F0; msb_first = 1;
    nx();
    wr = 0;
    chk("t1_level", level, 1);
    chk("t1_empty", empty, 0);
    chk("t1_ose_pre", ose, 1);
    chk("t1_ock_lo", ock, 0);
    nx();
    chk("t1_ock_hi", ock, 1);
    nx();
    chk("t1_sdo_pre", sdo, 0);
    nx();
    chk("t1_ock_fe", ock, 0);
    run_word(16'hA5F0, 1, 0);
    chk("t1_ose_end", ose, 1);
    chk("t1_sdo_end", sdo, 0);
    chk("t1_empty_end", empty, 1);
    chk("t1_chan_next", chan, 1);

    msb_first = 0; wr = 1; din = 16'h0001;
    nx();
    wr = 0;
    while (cyc < 72) nx();
    msb_first = 1;
    run_word(16'h0001, 0, 1);
    chk("t2_ose_end", ose, 1);
    chk("t2_chan_wrap", chan, 0);

    doen = 0; wr = 1; din = 16'h1234;
    nx(); din = 16'h8001;
    nx(); din = 16'h00FF;
    nx(); din = 16'hC3A5;
    nx();
    chk("t3_full", full, 1);
    chk("t3_level", level, 4);
    chk("t3_ovf_pre", ovf, 0);
    chk("t3_sdo_off", sdo, 0);
    chk("t3_ose_idle", ose, 1);
    din = 16'hDEAD;
    nx();
    chk("t3_ovf", ovf, 1);
    chk("t3_level_drop", level, 4);
    wr = 0; ovf_clr = 1;
    nx();
    chk("t3_ovf_clr", ovf, 0);
    ovf_clr = 0; doen = 1;
    nx();
    wr = 1; din = 16'h7E81;
    nx();
    wr = 0;
    chk("t4_level_pushpop", level, 4);
    chk("t4_full_pushpop", full, 1);
    chk("t4_ovf_pushpop", ovf, 0);
    run_word(16'h1234, 1, 0);
    run_word(16'h8001, 1, 1);
    run_word(16'h00FF, 1, 0);
    run_word(16'hC3A5, 1, 1);
    run_word(16'h7E81, 1, 0);
    chk("t4_ose_end", ose, 1);
    chk("t4_empty_end", empty, 1);
    chk("t4_chan_end", chan, 1);

    wr = 1; din = 16'hFFFF;
    nx();
    wr = 0;
    ones = 0;
    while (cyc < 544) begin
      if (cyc == 487) doen = 0;
      if (cyc == 499) doen = 1;
      #1;
      if (cyc >= 487 && cyc < 499) begin
        chk("t5_pause_sdo", sdo, 0);
        chk("t5_pause_ose", ose, 0);
      end
      if (cyc >= 468) ones += int'(sdo);
      nx();
    end
    chk("t5_ones", ones, 64);
    chk("t5_ose_end", ose, 1);
    chk("t5_sdo_end", sdo, 0);

    wr = 1; din = 16'hFFFF;
    while (cyc < 548) nx();
    wr = 0;
    while (cyc < 614) nx();
    chk("t6_chan_pre", chan, 1);
    chk("t6_level_pre", level, 2);
    chk("t6_ose_pre", ose, 0);
    chk("t6_sdo_pre", sdo, 1);
    rst = 1;
    #1;
    chk_reset();
    nx();
    nx();
    rst = 0;
    ones = 0;
    repeat (80) begin
      nx();
      ones += int'(sdo);
    end
    chk("t6_no_sdo", ones, 0);
    chk("t6_level_post", level, 0);
    chk("t6_ose_post", ose, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtdsp16_sout.md
# jtdsp16_sout

Parametrised serial output unit for the JTDSP16 core: a write FIFO feeding a shift engine that drives `ock`/`sdo`/`old`/`ose`, with configurable word width, FIFO depth, bit rate, channel count and bit order. It sits beside the parallel I/O on the core's `cen2` domain and replaces the fixed single-buffer serial output path. Multichannel audio streams (e.g. interleaved stereo) are tagged with a channel index for the external DAC.

## Interface

Parameters:
- `DW`, 16: serial word width in bits (8..32)
- `DEPTH`, 4: FIFO depth in words, power of two, ≥2
- `CKDIV`, 2: `cen` pulses per `ock` half-period, ≥1
- `CH`, 2: channels cycled word by word, ≥1

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `cen`  in  1  clock enable; all state except reset advances only when high
- `wr`  in  1  CPU write strobe, one word per `cen` cycle
- `din`  in  DW  word to enqueue
- `msb_first`  in  1  1: MSB shifted first; 0: LSB first; sampled at word load
- `ovf_clr`  in  1  clears `ovf`
- `doen`  in  1  data output enable
- `full`  out  1  FIFO holds DEPTH words
- `empty`  out  1  FIFO holds 0 words
- `level`  out  $clog2(DEPTH+1)  words in FIFO
- `ovf`  out  1  sticky: write dropped while full
- `ock`  out  1  serial bit clock, free-running
- `sdo`  out  1  serial data
- `old`  out  1  high for the first bit period of each word
- `ose`  out  1  shift engine idle
- `chan`  out  $clog2(CH) (min 1)  channel of word being shifted

## Operation

- Divider: counter 0..CKDIV-1 advances per `cen`; on wrap `ock` toggles. Period = 2·CKDIV `cen` pulses. "Falling edge" (FE) = the `cen` cycle in which `ock` goes 1→0. All engine events occur only at FE.
- FIFO: write accepted when `wr` and (not `full` or a pop occurs in the same cycle). Write while full without pop: dropped, `ovf`←1. `ovf_clr` clears `ovf`; simultaneous drop and clear leaves `ovf`=1. Simultaneous push+pop: `level` unchanged.
- Engine states: IDLE, SHIFT.
  - IDLE, FE, `doen`=1, not `empty`: pop head into shifter, latch `msb_first`, `sdo`←first bit, `old`←1, `ose`←0, bit counter←DW-1 → SHIFT.
  - SHIFT, FE, `doen`=1, counter>0: shift, `sdo`←next bit, `old`←0, counter−1.
  - SHIFT, FE, `doen`=1, counter=0 (last bit done): `chan`←(`chan`+1) mod CH; if not `empty` load next word as above (back-to-back, no gap bit), else `sdo`←0, `old`←0, `ose`←1 → IDLE.
  - Any FE with `doen`=0: engine holds state and counter; `sdo` forced 0 combinationally, `old` forced 0; `ock` keeps running.
- `chan` is the index of the word currently in the shifter; first word after reset is channel 0.

## Timing

- Reset values: `ock`=0, `sdo`=0, `old`=0, `ose`=1, `empty`=1, `full`=0, `level`=0, `ovf`=0, `chan`=0, divider=0, FIFO pointers=0, state IDLE. Reset mid-word aborts immediately; queued words are discarded.
- `level`/`full`/`empty` update in the cycle after an accepted `wr` (registered).
- First word latency: written word appears on `sdo` at the first FE after it is registered in the FIFO; `old` and first bit asserted for exactly 2·CKDIV `cen` pulses.
- Word duration DW·2·CKDIV `cen` pulses; continuous output while FIFO non-empty.
- Outputs all registered except `doen` gating of `sdo`/`old`.

## Test plan

- Defaults, `cen`=1: after reset write `din`=0xA5F0, `msb_first`=1 → `sdo` bits 1010 0101 1111 0000, each held 4 clk, `old`=1 first 4 clk only, `ose`=0 for 64 clk then 1, `chan`=0.
- `msb_first`=0, `din`=0x0001 → `sdo`=1 for first bit period, 0 for remaining 15.
- `doen`=0, write 5 words → `full`=1, `level`=4, `ovf`=1, fifth dropped; `ovf_clr` → `ovf`=0; `doen`=1 → four words emitted back-to-back, `chan` 0,1,0,1, `old` pulses at 64-clk spacing.
- Full FIFO, `wr` in the same cycle as a pop → write accepted, `level` stays 4, `ovf` stays 0.
- `doen` low for 3 bit periods after bit 5 of 0xFFFF → `sdo`=0 during pause, remaining 11 ones resume, word total 16 ones.
- `rst` pulse mid-word with 2 words queued → all outputs at reset values next cycle, no further `sdo` activity, `level`=0.
